// File: rtl/serial_nibble_rx.sv
// -----------------------------------------------------------------------------
// serial_nibble_rx
//
// Serial-to-parallel front end for the 4-to-16 one-hot decoder stage. Bits
// arrive one per qualified cycle on bit_in/bit_valid, are gathered into a
// 4-bit code, and handed to a single-entry holding register that drives the
// decoder input. Delivery to the downstream consumer uses a valid/ready
// handshake; a completed nibble that finds the holding register full (and
// not draining) is dropped and flagged on overrun.
//
// Optional feature macro: PARITY_CHECK_EN
//   When defined, every nibble is followed by a fifth serial bit carrying
//   even parity over the four data bits. A mismatching nibble is dropped and
//   flagged on parity_err. When undefined, parity_err is tied low.
//
// Parameters:
//   MSB_FIRST   1: first received bit lands in code_out[3]
//               0: first received bit lands in code_out[0]
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   bit_in      in   serial data bit, sampled when bit_valid=1
//   bit_valid   in   qualifies bit_in for one cycle
//   clear       in   synchronous abort of a partially received nibble
//   code_out    out  [3:0] assembled code (decoder input)
//   code_valid  out  code_out holds an undelivered code
//   code_ready  in   consumer accepts when code_valid & code_ready
//   overrun     out  one-cycle pulse: completed nibble dropped (register full)
//   parity_err  out  one-cycle pulse: parity mismatch (PARITY_CHECK_EN only)
//
// FSM states:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RECV   | collecting data bits, bit_cnt = number of data bits so far
//   PARITY | four data bits held in shreg, waiting for the parity bit
// -----------------------------------------------------------------------------
module serial_nibble_rx #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clear,
    output logic [3:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       overrun,
    output logic       parity_err
);

    typedef enum logic {
        RECV   = 1'b0,
        PARITY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] bit_cnt;
    logic [3:0] shreg;
    logic [3:0] shift_nxt;
    logic [3:0] nibble;

    logic       bit_take;
    logic       last_data;
    logic       shift_en;
    logic       commit_try;
    logic       commit_ok;
    logic       drain;
`ifdef PARITY_CHECK_EN
    logic       par_fail;
`endif

    // clear has priority over a coincident bit_valid
    assign bit_take  = bit_valid & ~clear;

    assign shift_nxt = MSB_FIRST ? {shreg[2:0], bit_in} : {bit_in, shreg[3:1]};

    assign last_data = (state == RECV) && bit_take && (bit_cnt == 3'd3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            RECV: begin
                if (last_data) begin
`ifdef PARITY_CHECK_EN
                    state_nxt = PARITY;
`else
                    state_nxt = RECV;
`endif
                end
            end
            PARITY: begin
                if (bit_take) begin
                    state_nxt = RECV;
                end
            end
            default: state_nxt = RECV;
        endcase
        if (clear) begin
            state_nxt = RECV;
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        shift_en   = 1'b0;
        commit_try = 1'b0;
        nibble     = shreg;
`ifdef PARITY_CHECK_EN
        par_fail   = 1'b0;
`endif
        case (state)
            RECV: begin
                shift_en = bit_take;
`ifndef PARITY_CHECK_EN
                // Without parity the 4th bit commits on the same edge it is
                // shifted, so the candidate is the post-shift value.
                commit_try = last_data;
                nibble     = shift_nxt;
`endif
            end
            PARITY: begin
`ifdef PARITY_CHECK_EN
                if (bit_take) begin
                    if (bit_in == ^shreg) begin
                        commit_try = 1'b1;
                    end else begin
                        par_fail = 1'b1;
                    end
                end
`endif
            end
            default: begin
                shift_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
        end else if (clear) begin
            bit_cnt <= 3'd0;
        end else if (bit_take) begin
`ifdef PARITY_CHECK_EN
            // In PARITY the counter sits at 4; the parity bit closes the frame.
            if (state == PARITY) begin
                bit_cnt <= 3'd0;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
`else
            if (last_data) begin
                bit_cnt <= 3'd0;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= 4'h0;
        end else if (clear) begin
            shreg <= 4'h0;
        end else if (shift_en) begin
            shreg <= shift_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    assign drain     = code_valid & code_ready;
    // A full register may still accept when it is being drained this cycle.
    assign commit_ok = commit_try & (~code_valid | code_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out   <= 4'h0;
            code_valid <= 1'b0;
        end else if (commit_ok) begin
            code_out   <= nibble;
            code_valid <= 1'b1;
        end else if (drain) begin
            // code_out is left as-is so the decoder output stays steady.
            code_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= commit_try & ~commit_ok;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_fail;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_nibble_rx.sv
module tb_serial_nibble_rx;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       code_ready;

    logic [3:0] out_m;
    logic       valid_m;
    logic       ovr_m;
    logic       perr_m;
    logic [3:0] out_l;
    logic       valid_l;
    logic       ovr_l;
    logic       perr_l;

`ifdef PARITY_CHECK_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    serial_nibble_rx #(.MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .code_out   (out_m),
        .code_valid (valid_m),
        .code_ready (code_ready),
        .overrun    (ovr_m),
        .parity_err (perr_m)
    );

    serial_nibble_rx #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .code_out   (out_l),
        .code_valid (valid_l),
        .code_ready (code_ready),
        .overrun    (ovr_l),
        .parity_err (perr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: bits of the current frame in arrival order
    bit         frame [5];
    int         nbits;
    logic [3:0] e_out_m;
    logic [3:0] e_out_l;
    logic       e_valid;
    logic       e_ovr;
    logic       e_perr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        nbits   = 0;
        e_out_m = 4'h0;
        e_out_l = 4'h0;
        e_valid = 1'b0;
        e_ovr   = 1'b0;
        e_perr  = 1'b0;
    endtask

    task automatic model_edge(input logic bv, input logic bi, input logic clr, input logic rdy);
        bit done;
        bit ok;
        bit take;
        int vm;
        int vl;
        done   = 0;
        take   = 0;
        e_ovr  = 1'b0;
        e_perr = 1'b0;
        if (clr) begin
            nbits = 0;
        end else if (bv) begin
            frame[nbits] = bi;
            nbits++;
            if (nbits == FRAME) begin
                done  = 1;
                nbits = 0;
            end
        end
        if (done) begin
            ok = 1;
            if (FRAME == 5) ok = (frame[4] == (frame[0] ^ frame[1] ^ frame[2] ^ frame[3]));
            if (!ok) e_perr = 1'b1;
            else if (!e_valid || rdy) take = 1;
            else e_ovr = 1'b1;
        end
        if (take) begin
            vm = 0;
            vl = 0;
            for (int i = 0; i < 4; i++) begin
                vm += int'(frame[i]) << (3 - i);
                vl += int'(frame[i]) << i;
            end
            e_out_m = vm[3:0];
            e_out_l = vl[3:0];
            e_valid = 1'b1;
        end else if (e_valid && rdy) begin
            e_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("out_msb",   {4'h0, out_m}, {4'h0, e_out_m});
        chk("out_lsb",   {4'h0, out_l}, {4'h0, e_out_l});
        chk("valid_msb", {7'h0, valid_m}, {7'h0, e_valid});
        chk("valid_lsb", {7'h0, valid_l}, {7'h0, e_valid});
        chk("ovr_msb",   {7'h0, ovr_m}, {7'h0, e_ovr});
        chk("ovr_lsb",   {7'h0, ovr_l}, {7'h0, e_ovr});
        chk("perr_msb",  {7'h0, perr_m}, {7'h0, e_perr});
        chk("perr_lsb",  {7'h0, perr_l}, {7'h0, e_perr});
    endtask

    // one clock: drive, advance past the edge, update model, compare
    task automatic cyc(input logic bv, input logic bi, input logic clr, input logic rdy);
        bit_valid  = bv;
        bit_in     = bi;
        clear      = clr;
        code_ready = rdy;
        @(posedge clk);
        model_edge(bv, bi, clr, rdy);
        #1;
        check_all();
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    // send val bit 3 first; with parity, append the correct parity bit
    task automatic send(input logic [3:0] val, input logic rdy_body, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0 && FRAME == 4) cyc(1'b1, val[i], 1'b0, rdy_last);
            else cyc(1'b1, val[i], 1'b0, rdy_body);
        end
        if (FRAME == 5) cyc(1'b1, ^val, 1'b0, rdy_last);
    endtask

    initial begin
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clear      = 1'b0;
        code_ready = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset in the middle of a nibble
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_mid_out", {4'h0, out_m}, 8'h00);
        chk("rst_mid_valid", {7'h0, valid_m}, 8'h00);
        #1;
        rst_n = 1'b1;
        send(4'hB, 1'b0, 1'b0);
        chk("first_B", {4'h0, out_m}, 8'h0B);
        chk("first_B_lsb", {4'h0, out_l}, 8'h0D);
        chk("first_B_valid", {7'h0, valid_m}, 8'h01);

        // backpressure and overrun
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_B", {7'h0, valid_m}, 8'h00);
        send(4'h3, 1'b0, 1'b0);
        send(4'hC, 1'b0, 1'b0);
        chk("ovr_keep3", {4'h0, out_m}, 8'h03);
        chk("ovr_pulse", {7'h0, ovr_m}, 8'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_once", {7'h0, ovr_m}, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ready_drop", {7'h0, valid_m}, 8'h00);

        // simultaneous drain and fill
        send(4'h5, 1'b0, 1'b0);
        send(4'hA, 1'b0, 1'b1);
        chk("dfill_out", {4'h0, out_m}, 8'h0A);
        chk("dfill_valid", {7'h0, valid_m}, 8'h01);
        chk("dfill_ovr", {7'h0, ovr_m}, 8'h00);

        // clear wins over a coincident bit_valid
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send(4'h6, 1'b0, 1'b0);
        chk("clear_6", {4'h0, out_m}, 8'h06);

        // LSB-first orientation: bits 1,0,0,0
        send(4'h8, 1'b1, 1'b1);
        chk("lsb_1", {4'h0, out_l}, 8'h01);
        chk("lsb_1_msb", {4'h0, out_m}, 8'h08);

        // continuous bit_valid with consumer always ready
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
        send(4'h7, 1'b1, 1'b1);
        chk("par_ok_7", {4'h0, out_m}, 8'h07);
        for (int i = 3; i >= 0; i--) cyc(1'b1, (i == 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("par_err", {7'h0, perr_m}, 8'h01);
        chk("par_no_ovr", {7'h0, ovr_m}, 8'h00);
        chk("par_valid", {7'h0, valid_m}, 8'h01);
        chk("par_keep7", {4'h0, out_m}, 8'h07);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_err_once", {7'h0, perr_m}, 8'h00);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(99, 0) < 1) reset_pulse();
            cyc(1'($urandom_range(99, 0) < 75),
                1'($urandom_range(1, 0)),
                1'($urandom_range(99, 0) < 4),
                1'($urandom_range(99, 0) < 45));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
